seg7_multi_digit_counter: RTL

- Multi-digit BCD up/down event counter with a time-multiplexed 7-segment display driver.
- Generalised successor of the single-digit switch counter: parametrised digit count, scan rate, output polarities and leading-zero blanking.
- Adds decrement, clear, wrap flag and a parallel BCD output.
- Sits between the debounce filters (already-debounced level inputs) and the board segment/digit pins.

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_scan_ctrl.sv | 31 +++
 rtl/seg7_multi_digit_counter.sv | 85 ++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// seg7_pkg: BCD digit type, active-high segment patterns and BCD step helpers
package seg7_pkg;
  typedef logic [3:0] bcd_digit_t;
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  function automatic logic [6:0] bcd_to_seg(bcd_digit_t d);
    case (d)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return 7'b0000000;
    endcase
  endfunction
  function automatic logic [4:0] bcd_inc(bcd_digit_t d, logic ci);
    return !ci ? {1'b0, d} : (d == 4'd9) ? 5'b1_0000 : {1'b0, d + 4'd1};
  endfunction
  function automatic logic [4:0] bcd_dec(bcd_digit_t d, logic bi);
    return !bi ? {1'b0, d} : (d == 4'd0) ? {1'b1, 4'd9} : {1'b0, d - 4'd1};
  endfunction
endpackage

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: prescaler and digit scan index, outputs one-hot select and current index
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1,
  localparam int PW = $clog2(CLKS_PER_DIGIT)
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  output logic [NUM_DIGITS-1:0] o_Sel,
  output logic [IW-1:0]         o_Idx
);
  logic [PW-1:0] pre_q, pre_d;
  logic [IW-1:0] idx_q, idx_d;
  logic term;
  always_comb begin
    term = pre_q == PW'(CLKS_PER_DIGIT - 1);
    pre_d = term ? '0 : pre_q + 1'b1;
    idx_d = !term ? idx_q : (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      pre_q <= '0;
      idx_q <= '0;
    end else begin
      pre_q <= pre_d;
      idx_q <= idx_d;
    end
  assign o_Sel = NUM_DIGITS'(1) << idx_q;
  assign o_Idx = idx_q;
endmodule

// File: rtl/seg7_multi_digit_counter.sv
// seg7_multi_digit_counter: BCD up/down event counter driving a multiplexed 7-segment display
module seg7_multi_digit_counter
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int CLKS_PER_DIGIT = 25000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1,
  parameter bit BLANK_LEAD_ZERO = 1'b1
) (
  input  logic                    i_Clk,
  input  logic                    i_Rst_n,
  input  logic                    i_Inc,
  input  logic                    i_Dec,
  input  logic                    i_Clear,
  output logic [6:0]              o_Segment,
  output logic [NUM_DIGITS-1:0]   o_Digit,
  output logic [4*NUM_DIGITS-1:0] o_Count_BCD,
  output logic                    o_Wrap
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic inc_q, inc_d, dec_q, dec_d, wrap_q, wrap_d, inc_evt, dec_evt, blank;
  logic [4*NUM_DIGITS-1:0] count_q, count_d, inc_val, dec_val;
  logic [NUM_DIGITS:0] cy, bw, lz;
  logic [6:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d, sel;
  logic [IW-1:0] idx;
  bcd_digit_t cur;
  seg7_scan_ctrl #(.NUM_DIGITS(NUM_DIGITS), .CLKS_PER_DIGIT(CLKS_PER_DIGIT)) u_scan (
    .i_Clk(i_Clk),
    .i_Rst_n(i_Rst_n),
    .o_Sel(sel),
    .o_Idx(idx)
  );
  always_comb begin
    inc_d = i_Inc;
    dec_d = i_Dec;
    inc_evt = i_Inc & ~inc_q;
    dec_evt = i_Dec & ~dec_q;
    cy = '0;
    bw = '0;
    inc_val = '0;
    dec_val = '0;
    cy[0] = 1'b1;
    bw[0] = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      {cy[k+1], inc_val[4*k +: 4]} = bcd_inc(count_q[4*k +: 4], cy[k]);
      {bw[k+1], dec_val[4*k +: 4]} = bcd_dec(count_q[4*k +: 4], bw[k]);
    end
    count_d = i_Clear ? '0 : (inc_evt & ~dec_evt) ? inc_val : (dec_evt & ~inc_evt) ? dec_val : count_q;
    wrap_d = ~i_Clear & ((inc_evt & ~dec_evt & cy[NUM_DIGITS]) | (dec_evt & ~inc_evt & bw[NUM_DIGITS]));
    lz = '0;
    lz[NUM_DIGITS] = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) lz[k] = lz[k+1] & (count_q[4*k +: 4] == 4'd0);
    cur = '0;
    blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++)
      if (idx == IW'(k)) begin
        cur = count_q[4*k +: 4];
        blank = BLANK_LEAD_ZERO && (k > 0) && lz[k];
      end
    seg_d = (blank ? 7'd0 : bcd_to_seg(cur)) ^ {7{SEG_ACTIVE_LOW}};
    dig_d = sel ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
  end
  always_ff @(posedge i_Clk or negedge i_Rst_n)
    if (!i_Rst_n) begin
      inc_q <= 1'b0;
      dec_q <= 1'b0;
      count_q <= '0;
      wrap_q <= 1'b0;
      seg_q <= {7{SEG_ACTIVE_LOW}};
      dig_q <= {NUM_DIGITS{DIG_ACTIVE_LOW}};
    end else begin
      inc_q <= inc_d;
      dec_q <= dec_d;
      count_q <= count_d;
      wrap_q <= wrap_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
    end
  assign o_Segment = seg_q;
  assign o_Digit = dig_q;
  assign o_Count_BCD = count_q;
  assign o_Wrap = wrap_q;
endmodule
